// File: rtl/inst_encoder.sv
// RV32I field-set encoder feeding a small output FIFO.
// Unsupported op_codes store a NOP tagged with an error bit and bump a saturating counter.
module inst_encoder #(
    parameter int RS    = 5,
    parameter int RD    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 op_code,
    input  logic [3:0]                 sub_op_code,
    input  logic [RS-1:0]              rs1,
    input  logic [RS-1:0]              rs2,
    input  logic [RD-1:0]              rd,
    input  logic [31:0]                imm,
    input  logic [4:0]                 shift_size,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [4:0] {
        OP_LOAD   = 5'b00000,
        OP_IMM    = 5'b00100,
        OP_AUIPC  = 5'b00101,
        OP_STORE  = 5'b01000,
        OP_REG    = 5'b01100,
        OP_LUI    = 5'b01101,
        OP_BRANCH = 5'b11000,
        OP_JALR   = 5'b11001,
        OP_JAL    = 5'b11011
    } opcode_e;

    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic [2:0]  f3;
    logic        b30;
    logic [31:0] enc_inst;
    logic        enc_err;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    // Register indices are normalised to the 5-bit instruction fields.
    always_comb begin
        rs1_f = 5'(rs1);
        rs2_f = 5'(rs2);
        rd_f  = 5'(rd);
        f3    = sub_op_code[2:0];
        b30   = sub_op_code[3];
    end

    always_comb begin
        enc_inst = NOP;
        enc_err  = 1'b0;
        case (op_code)
            OP_LUI, OP_AUIPC:
                enc_inst = {imm[31:12], rd_f, op_code, 2'b11};
            OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101)
                    enc_inst = {1'b0, b30, 5'b00000, shift_size, rs1_f, f3, rd_f, op_code, 2'b11};
                else
                    enc_inst = {imm[11:0], rs1_f, f3, rd_f, op_code, 2'b11};
            end
            OP_REG:
                enc_inst = {1'b0, b30, 5'b00000, rs2_f, rs1_f, f3, rd_f, op_code, 2'b11};
            OP_LOAD:
                enc_inst = {imm[11:0], rs1_f, f3, rd_f, op_code, 2'b11};
            OP_STORE:
                enc_inst = {imm[11:5], rs2_f, rs1_f, f3, imm[4:0], op_code, 2'b11};
            OP_JAL:
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd_f, op_code, 2'b11};
            OP_JALR:
                enc_inst = {imm[11:0], rs1_f, 3'b000, rd_f, op_code, 2'b11};
            OP_BRANCH:
                enc_inst = {imm[12], imm[10:5], rs2_f, rs1_f, f3, imm[4:1], imm[11], op_code, 2'b11};
            default: begin
                enc_inst = NOP;
                enc_err  = 1'b1;
            end
        endcase
    end

    // in_ready looks only at occupancy, so a full FIFO refuses a push even during a pop.
    always_comb begin
        in_ready  = rst_n && (count < FULL);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_inst  = out_valid ? mem[rd_ptr][31:0] : '0;
        out_err   = out_valid ? mem[rd_ptr][32]   : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {enc_err, enc_inst};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && enc_err && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: vector table through a scoreboard plus back-pressure,
// error-counter saturation and mid-traffic reset sequences.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op_code = '0;
    logic [3:0]  sub_op_code = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] imm = '0;
    logic [4:0]  shift_size = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [2:0]  count;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  sub;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    logic [32:0] sb[$];
    vec_t        tbl[14];

    inst_encoder #(.RS(5), .RD(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .sub_op_code(sub_op_code), .rs1(rs1), .rs2(rs2),
        .rd(rd), .imm(imm), .shift_size(shift_size), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
        .count(count), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [3:0] sub,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                input logic [31:0] im, input logic [4:0] sh,
                                input logic [31:0] inst, input logic err);
        vec_t v;
        v.op = op; v.sub = sub; v.rs1 = r1; v.rs2 = r2; v.rd = d;
        v.imm = im; v.sh = sh; v.inst = inst; v.err = err;
        return v;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, before the rising edge that pops.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", out_inst, 32'hxxxx_xxxx);
            end else begin
                chk("out_inst", out_inst, sb[0][31:0]);
                chk("out_err", {31'd0, out_err}, {31'd0, sb[0][32]});
                if (out_ready)
                    void'(sb.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        bit done = 0;
        op_code = v.op; sub_op_code = v.sub; rs1 = v.rs1; rs2 = v.rs2;
        rd = v.rd; imm = v.imm; shift_size = v.sh;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({v.err, v.inst});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(5'b00100, 4'b0000, 5'd0, 5'd0, 5'd1, 32'd5,          5'd0,  32'h00500093, 1'b0); // addi
        tbl[1]  = mk(5'b01100, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd0,          5'd0,  32'h402081B3, 1'b0); // sub
        tbl[2]  = mk(5'b01000, 4'b0010, 5'd1, 5'd2, 5'd0, 32'd8,          5'd0,  32'h0020A423, 1'b0); // sw
        tbl[3]  = mk(5'b11000, 4'b0000, 5'd1, 5'd2, 5'd0, 32'd16,         5'd0,  32'h00208863, 1'b0); // beq
        tbl[4]  = mk(5'b01101, 4'b0000, 5'd0, 5'd0, 5'd5, 32'h12345000,   5'd0,  32'h123452B7, 1'b0); // lui
        tbl[5]  = mk(5'b00101, 4'b0000, 5'd0, 5'd0, 5'd1, 32'h00001000,   5'd0,  32'h00001097, 1'b0); // auipc
        tbl[6]  = mk(5'b00100, 4'b0001, 5'd3, 5'd0, 5'd2, 32'h00000FFF,   5'd4,  32'h00419113, 1'b0); // slli
        tbl[7]  = mk(5'b00100, 4'b1101, 5'd1, 5'd0, 5'd1, 32'd0,          5'd31, 32'h41F0D093, 1'b0); // srai
        tbl[8]  = mk(5'b00000, 4'b0010, 5'd2, 5'd0, 5'd6, 32'hFFFFFFFC,   5'd0,  32'hFFC12303, 1'b0); // lw
        tbl[9]  = mk(5'b11011, 4'b0000, 5'd0, 5'd0, 5'd1, 32'h00000800,   5'd0,  32'h001000EF, 1'b0); // jal
        tbl[10] = mk(5'b11001, 4'b0111, 5'd1, 5'd0, 5'd0, 32'd0,          5'd0,  32'h00008067, 1'b0); // jalr
        tbl[11] = mk(5'b11000, 4'b0001, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8,   5'd0,  32'hFE209CE3, 1'b0); // bne
        tbl[12] = mk(5'b00100, 4'b1111, 5'd1, 5'd0, 5'd1, 32'h000000FF,   5'd0,  32'h0FF0F093, 1'b0); // andi
        tbl[13] = mk(5'b11111, 4'b0000, 5'd1, 5'd2, 5'd3, 32'h12345678,   5'd7,  32'h00000013, 1'b1); // unsupported

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_count",     {29'd0, count},     32'd0);
        chk("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
        chk("rst_out_inst",  out_inst,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Vector table, back-to-back with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) send(tbl[i]);
        drain();
        chk("err_cnt_table", {24'd0, err_cnt}, 32'd1);

        // Back-pressure: four fill the FIFO, the fifth waits for a pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(tbl[i + 4]);
        chk("bp_count_full", {29'd0, count}, 32'd4);
        chk("bp_in_ready",   {31'd0, in_ready}, 32'd0);
        op_code = tbl[8].op; sub_op_code = tbl[8].sub; rs1 = tbl[8].rs1; rs2 = tbl[8].rs2;
        rd = tbl[8].rd; imm = tbl[8].imm; shift_size = tbl[8].sh;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_count_hold", {29'd0, count}, 32'd4);
        chk("bp_head_hold",  out_inst, tbl[4].inst);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_no_push_on_pop", {29'd0, count}, 32'd3);
        send(tbl[8]);
        chk("bp_count_refill", {29'd0, count}, 32'd4);
        drain();

        // Error counter: first unsupported after reset, then saturation
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("err_rst", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(tbl[13]);
        #1;
        chk("err_cnt_one", {24'd0, err_cnt}, 32'd1);
        for (int i = 0; i < 299; i++) send(tbl[13]);
        drain();
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        // Reset with three words in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(tbl[i]);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count",     {29'd0, count},     32'd0);
        chk("mid_rst_err_cnt",   {24'd0, err_cnt},   32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("mid_rst_out_inst",  out_inst,           32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        send(tbl[12]);
        chk("post_rst_count", {29'd0, count}, 32'd1);
        chk("post_rst_head",  out_inst, tbl[12].inst);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
